serial_subtractor: RTL and testbench

//   Bit-serial N-bit subtractor: diff = a - b, LSB-first, one full-subtractor cell per clock.

---
 rtl/serial_sub_pkg.sv | 24 ++
 rtl/serial_subtractor_fs_cell.sv | 16 +
 rtl/serial_subtractor.sv | 127 ++++++++++++
 tb/tb_serial_subtractor.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared definitions for the bit-serial subtractor.
// Holds the FSM state encoding and the full-subtractor truth tables,
// indexed by {a, b, bin}.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Difference output of one full-subtractor cell, bit index {a, b, bin}
    localparam logic [7:0] FS_D_TT    = 8'b1001_0110;
    // Borrow output of one full-subtractor cell, bit index {a, b, bin}
    localparam logic [7:0] FS_BOUT_TT = 8'b1000_1110;

    // Table lookup form of the cell, returns {bout, d}
    function automatic logic [1:0] fs_eval(input logic a, input logic b, input logic bin);
        logic [2:0] idx;
        idx = {a, b, bin};
        return {FS_BOUT_TT[idx], FS_D_TT[idx]};
    endfunction

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// fs_cell: combinational one-bit full subtractor, d = a - b - bin.
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference and borrow-out of a single bit position
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~a & bin) | (b & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, diff = a - b, LSB first,
// one full-subtractor cell evaluated per clock with a single borrow flop.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed overflow output.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             bflop;
    logic [CW-1:0]    cnt;
    logic             cell_d;
    logic             cell_bout;
    logic             accept;
    logic             last_bit;

    fs_cell u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (bflop),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign accept   = (state == IDLE) && in_valid;
    assign last_bit = (state == RUN) && (cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (cnt == CNT_LAST) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand shifting, borrow chain and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            bflop  <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            bflop <= 1'b0;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= {cell_d, res_sh[WIDTH-1:1]};
            bflop  <= cell_bout;
            if (last_bit) begin
                // Publish the full result, including this final bit, as DONE is entered
                diff   <= {cell_d, res_sh[WIDTH-1:1]};
                borrow <= cell_bout;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;

    // Operand sign capture and signed overflow, registered with diff
    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (last_bit) begin
            overflow <= (a_msb != b_msb) && (cell_d != a_msb);
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor (WIDTH=8).
// Honours SERIAL_SUB_OVF_EN to connect and check the overflow port.
module tb_serial_subtractor;

    localparam int WIDTH = 8;
`ifdef SERIAL_SUB_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             bo;
        logic             ov;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic             overflow;
`endif

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        exp_t m;
        int   s;
        s    = int'($signed(x)) - int'($signed(y));
        m.d  = x - y;
        m.bo = (x < y);
        m.ov = OVF_EN && (s > 127 || s < -128);
        return m;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o.d  = diff;
        o.bo = borrow;
`ifdef SERIAL_SUB_OVF_EN
        o.ov = overflow;
`else
        o.ov = 1'b0;
`endif
        return o;
    endfunction

    // Present one operand pair at a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input bit intrude);
        int t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        sb.push_back(model(x, y));
        a = x;
        b = y;
        in_valid = 1'b1;
        @(negedge clk);
        if (intrude) begin
            a = 8'hAA;
            b = 8'h55;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 4 * WIDTH) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        exp_t got;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        got = observed();
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
        end
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b, expected 0", out_valid);
        end
        n_tests++;
        if (got !== exp_t'('0)) begin
            n_fail++;
            $display("FAIL reset_result: got d=%h b=%b o=%b, expected all zero", got.d, got.bo, got.ov);
        end
    endtask

    task automatic run_pairs(input string name, input logic [WIDTH-1:0] xs[], input logic [WIDTH-1:0] ys[]);
        int   lat;
        exp_t e;
        exp_t got;
        out_ready = 1'b1;
        for (int i = 0; i < xs.size(); i++) begin
            issue(xs[i], ys[i], 1'b0);
            n_tests++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_busy[%0d]: in_ready got %b, expected 0", name, i, in_ready);
            end
            wait_done(lat);
            n_tests++;
            if (lat != WIDTH) begin
                n_fail++;
                $display("FAIL %s_latency[%0d]: got %0d, expected %0d", name, i, lat, WIDTH);
            end
            e   = sb.pop_front();
            got = observed();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL %s_result[%0d] %h-%h: got d=%h b=%b o=%b, expected d=%h b=%b o=%b",
                         name, i, xs[i], ys[i], got.d, got.bo, got.ov, e.d, e.bo, e.ov);
            end
            @(negedge clk);
            n_tests++;
            if ({out_valid, in_ready} !== 2'b01) begin
                n_fail++;
                $display("FAIL %s_release[%0d]: out_valid,in_ready got %b%b, expected 01",
                         name, i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] xs[] = '{8'h05, 8'h03, 8'h00};
        logic [WIDTH-1:0] ys[] = '{8'h03, 8'h05, 8'h00};
        run_pairs("basic", xs, ys);
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] xs[] = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'hFF, 8'h80};
        logic [WIDTH-1:0] ys[] = '{8'h01, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h7F};
        run_pairs("edge", xs, ys);
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] xs[] = new[24];
        logic [WIDTH-1:0] ys[] = new[24];
        for (int i = 0; i < 24; i++) begin
            xs[i] = WIDTH'($urandom_range(0, 255));
            ys[i] = WIDTH'($urandom_range(0, 255));
        end
        run_pairs("random", xs, ys);
    endtask

    task automatic test_backpressure();
        int   lat;
        exp_t e;
        exp_t got;
        out_ready = 1'b0;
        issue(8'h05, 8'h03, 1'b0);
        wait_done(lat);
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            got = observed();
            n_tests++;
            if (out_valid !== 1'b1 || got !== e) begin
                n_fail++;
                $display("FAIL hold[%0d]: got out_valid=%b d=%h b=%b, expected out_valid=1 d=%h b=%b",
                         i, out_valid, got.d, got.bo, e.d, e.bo);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL hold_release: out_valid,in_ready got %b%b, expected 01", out_valid, in_ready);
        end
    endtask

    task automatic test_ignore_in_run();
        int   lat;
        exp_t e;
        exp_t got;
        out_ready = 1'b1;
        issue(8'h40, 8'h11, 1'b1);
        wait_done(lat);
        in_valid = 1'b0;
        e   = sb.pop_front();
        got = observed();
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL ignore_result: got d=%h b=%b o=%b, expected d=%h b=%b o=%b",
                     got.d, got.bo, got.ov, e.d, e.bo, e.ov);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL ignore_no_accept: out_valid,in_ready got %b%b, expected 01", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        int   period;
        exp_t e;
        exp_t got;
        out_ready = 1'b1;
        sb.push_back(model(8'h9C, 8'h27));
        sb.push_back(model(8'h21, 8'h64));
        a = 8'h9C;
        b = 8'h27;
        in_valid = 1'b1;
        @(negedge clk);
        wait_done(lat);
        e   = sb.pop_front();
        got = observed();
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL b2b_first: got d=%h b=%b, expected d=%h b=%b", got.d, got.bo, e.d, e.bo);
        end
        a = 8'h21;
        b = 8'h64;
        period = 0;
        do begin
            @(negedge clk);
            period++;
        end while (out_valid !== 1'b1 && period < 40);
        in_valid = 1'b0;
        n_tests++;
        if (period != WIDTH + 2) begin
            n_fail++;
            $display("FAIL b2b_period: got %0d, expected %0d", period, WIDTH + 2);
        end
        e   = sb.pop_front();
        got = observed();
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL b2b_second: got d=%h b=%b, expected d=%h b=%b", got.d, got.bo, e.d, e.bo);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int   lat;
        exp_t e;
        exp_t got;
        out_ready = 1'b1;
        issue(8'h33, 8'h11, 1'b0);
        void'(sb.pop_back());
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        got = observed();
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01 || got !== exp_t'('0)) begin
            n_fail++;
            $display("FAIL abort: got out_valid=%b in_ready=%b d=%h b=%b o=%b, expected 0 1 00 0 0",
                     out_valid, in_ready, got.d, got.bo, got.ov);
        end
        issue(8'h10, 8'h01, 1'b0);
        wait_done(lat);
        n_tests++;
        if (lat != WIDTH) begin
            n_fail++;
            $display("FAIL after_abort_latency: got %0d, expected %0d", lat, WIDTH);
        end
        e   = sb.pop_front();
        got = observed();
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL after_abort_result: got d=%h b=%b, expected d=%h b=%b", got.d, got.bo, e.d, e.bo);
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_ignore_in_run();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
